// File: rtl/rf_dump_reader.sv
// Walks a register-file address range through the test port and streams {addr, data} beats.
// Optional RF_DUMP_SKIPZERO_EN: registers reading zero are skipped rather than emitted.
module rf_dump_reader #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int SETTLE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_addr,
    input  logic [ADDR_W-1:0] last_addr,
    output logic [ADDR_W-1:0] sw_address,
    input  logic [DATA_W-1:0] testReg,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETA,
        S_WAIT,
        S_SEND,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cur_q, cur_d;
    logic [ADDR_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]  sw_address_q, sw_address_d;
    logic               out_valid_q, out_valid_d;
    logic [ADDR_W-1:0]  out_addr_q, out_addr_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               advance;

    always_comb begin
        state_d      = state_q;
        cur_d        = cur_q;
        last_d       = last_q;
        cnt_d        = cnt_q;
        sw_address_d = sw_address_q;
        out_valid_d  = out_valid_q;
        out_addr_d   = out_addr_q;
        out_data_d   = out_data_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        advance      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cur_d   = first_addr;
                    last_d  = last_addr;
                    busy_d  = 1'b1;
                    state_d = S_SETA;
                end
            end
            S_SETA: begin
                sw_address_d = cur_q;
                cnt_d        = CNT_W'(SETTLE - 1);
                state_d      = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
`ifdef RF_DUMP_SKIPZERO_EN
                    if (testReg == '0) begin
                        advance = 1'b1;
                    end else begin
                        out_data_d  = testReg;
                        out_addr_d  = cur_q;
                        out_valid_d = 1'b1;
                        state_d     = S_SEND;
                    end
`else
                    out_data_d  = testReg;
                    out_addr_d  = cur_q;
                    out_valid_d = 1'b1;
                    state_d     = S_SEND;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    advance     = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Shared by a completed handshake and (optionally) a skipped zero register.
        if (advance) begin
            if (cur_q == last_q) begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end else begin
                cur_d   = cur_q + ADDR_W'(1);
                state_d = S_SETA;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cur_q        <= '0;
            last_q       <= '0;
            cnt_q        <= '0;
            sw_address_q <= '0;
            out_valid_q  <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            last_q       <= last_d;
            cnt_q        <= cnt_d;
            sw_address_q <= sw_address_d;
            out_valid_q  <= out_valid_d;
            out_addr_q   <= out_addr_d;
            out_data_q   <= out_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign sw_address = sw_address_q;
    assign out_valid  = out_valid_q;
    assign out_addr   = out_addr_q;
    assign out_data   = out_data_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_rf_dump_reader.sv
// Bench for rf_dump_reader: directed scenarios plus randomized dumps against a queue-based model.
module tb_rf_dump_reader;

    localparam int AW   = 5;
    localparam int DW   = 32;
    localparam int NREG = 32;
`ifdef RF_DUMP_SKIPZERO_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] first_addr;
    logic [AW-1:0] last_addr;
    logic [AW-1:0] sw_address;
    logic [DW-1:0] testReg;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_addr;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;

    logic [DW-1:0] regs [NREG];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign testReg = regs[sw_address];

    rf_dump_reader #(.ADDR_W(AW), .DATA_W(DW), .SETTLE(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .first_addr (first_addr),
        .last_addr  (last_addr),
        .sw_address (sw_address),
        .testReg    (testReg),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .busy       (busy),
        .done       (done)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 5 valid cycles per beat
    task automatic run_dump(input logic [AW-1:0] f, input logic [AW-1:0] l, input int mode,
                            input int restart_at, input bit check_lat);
        logic [AW+DW-1:0] exp_q[$];
        logic [AW+DW-1:0] e;
        logic [AW-1:0]    a;
        logic [AW-1:0]    pa;
        logic [DW-1:0]    pd;
        logic             pv, phs;
        int n, cyc, budget, vcnt, first_valid, done_cyc;
        bit seen_done;

        n = ((int'(l) - int'(f) + NREG) % NREG) + 1;
        for (int i = 0; i < n; i++) begin
            a = AW'((int'(f) + i) % NREG);
            if (!SKIP || regs[a] != '0) exp_q.push_back({a, regs[a]});
        end

        @(negedge clk);
        start = 1'b1; first_addr = f; last_addr = l; out_ready = (mode == 0);
        cyc = 0; budget = 12 * n + 40; vcnt = 0; first_valid = -1; done_cyc = -1;
        pv = 1'b0; phs = 1'b0; pa = '0; pd = '0; seen_done = 1'b0;

        while (!seen_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (restart_at != 0 && cyc == restart_at) begin
                start = 1'b1; first_addr = AW'(5); last_addr = AW'($urandom);
            end else begin
                start = 1'b0;
            end
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = (vcnt >= 5);
            endcase
            #1;
            if (cyc == 1) check("busy_after_start", busy, 1);
            if (pv && !phs) begin
                check("hold_valid", out_valid, 1);
                check("hold_addr", out_addr, pa);
                check("hold_data", out_data, pd);
            end
            if (out_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_addr", out_addr, e[AW+DW-1:DW]);
                        check("beat_data", out_data, e[DW-1:0]);
                    end
                    vcnt = 0;
                end else begin
                    vcnt++;
                end
            end
            pv = out_valid; phs = out_valid && out_ready; pa = out_addr; pd = out_data;
            if (done) begin
                seen_done = 1'b1;
                done_cyc  = cyc;
                check("busy_at_done", busy, 0);
                check("valid_at_done", out_valid, 0);
            end
        end
        if (!seen_done) check("done_timeout", 0, 1);
        check("beats_missing", exp_q.size(), 0);
        @(negedge clk);
        #1;
        check("done_one_cycle", done, 0);
        check("busy_after_done", busy, 0);
        if (check_lat && !SKIP) begin
            check("first_valid_latency", first_valid, 3);
            check("done_latency", done_cyc, 3 * n + 1);
        end
    endtask

    initial begin
        bit saw_done;
        rst = 1'b1; start = 1'b0; first_addr = '0; last_addr = '0; out_ready = 1'b0;
        for (int i = 0; i < NREG; i++) regs[i] = 32'(i * 32'h11);
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_swaddr", sw_address, 0);
        check("rst_addr", out_addr, 0);
        check("rst_data", out_data, 0);
        @(negedge clk);
        rst = 1'b0;

        // T1: reset while a beat is waiting in SEND
        regs[2] = 32'hDEAD_0002;
        start = 1'b1; first_addr = AW'(2); last_addr = AW'(4); out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !out_valid; i++) begin
            @(negedge clk);
            #1;
        end
        check("t1_reached_send", out_valid, 1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("t1_valid", out_valid, 0);
        check("t1_busy", busy, 0);
        check("t1_done", done, 0);
        check("t1_swaddr", sw_address, 0);
        rst = 1'b0; out_ready = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            saw_done |= done;
        end
        check("t1_no_done_after_abort", saw_done, 0);
        regs[2] = 32'h22;

        // T2: full dump with ready high, including latency
        run_dump(AW'(0), AW'(31), 0, 0, 1'b1);

        // T3: single register with 5 cycles of backpressure
        regs[16] = 32'h17;
        run_dump(AW'(16), AW'(16), 2, 0, 1'b0);

        // T4: wrap-around range
        run_dump(AW'(30), AW'(1), 0, 0, 1'b1);

        // T5: start while busy is ignored
        run_dump(AW'(10), AW'(14), 1, 4, 1'b0);

        // T6: zero registers in range
        regs[0] = '0; regs[1] = 32'hA; regs[2] = '0; regs[3] = '0;
        run_dump(AW'(0), AW'(3), 0, 0, 1'b0);

        // all-zero range: done only when skipping, otherwise zero beats emitted
        regs[20] = '0; regs[21] = '0;
        run_dump(AW'(20), AW'(21), 1, 0, 1'b0);

        // randomized contents, ranges and backpressure
        for (int k = 0; k < 6; k++) begin
            for (int i = 0; i < NREG; i++)
                regs[i] = ($urandom_range(0, 3) == 0) ? '0 : $urandom;
            run_dump(AW'($urandom), AW'($urandom), 1, 0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
